psum_accum_requant: RTL and testbench

//  Consumer end of the MAC array core's result interface. Takes the aligned psum_3x3 / psum_1x1 / identity

---
 rtl/psum_accum_requant_pkg.sv | 37 +++
 rtl/psum_accum_requant_ofm_fifo.sv | 56 +++++
 rtl/psum_accum_requant.sv | 208 ++++++++++++++++++++
 tb/tb_psum_accum_requant.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/psum_accum_requant_pkg.sv
// Shared widths, FSM encoding and output saturation for the psum accumulator / requantizer.
package psum_accum_requant_pkg;

    localparam int unsigned ACC_W  = 32;
    localparam int unsigned P3_W   = 32;
    localparam int unsigned P1_W   = 24;
    localparam int unsigned PROD_W = 48;
    localparam int unsigned OFM_W  = 8;

    localparam logic signed [PROD_W-1:0] CLAMP_U_MIN = PROD_W'(0);
    localparam logic signed [PROD_W-1:0] CLAMP_U_MAX = PROD_W'(255);
    localparam logic signed [PROD_W-1:0] CLAMP_S_MIN = PROD_W'(-128);
    localparam logic signed [PROD_W-1:0] CLAMP_S_MAX = PROD_W'(127);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    // Saturate a shifted product to uint8 (relu) or int8.
    function automatic logic [OFM_W-1:0] sat_ofm(input logic signed [PROD_W-1:0] q,
                                                 input logic relu);
        logic [OFM_W-1:0] r;
        if (relu) begin
            if (q < CLAMP_U_MIN)      r = OFM_W'(CLAMP_U_MIN);
            else if (q > CLAMP_U_MAX) r = OFM_W'(CLAMP_U_MAX);
            else                      r = q[OFM_W-1:0];
        end else begin
            if (q < CLAMP_S_MIN)      r = OFM_W'(CLAMP_S_MIN);
            else if (q > CLAMP_S_MAX) r = OFM_W'(CLAMP_S_MAX);
            else                      r = q[OFM_W-1:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/psum_accum_requant_ofm_fifo.sv
// First-word-fall-through synchronous FIFO with occupancy count; push on full is accepted
// only when a pop frees the slot in the same cycle.
module ofm_sync_fifo
    import psum_accum_requant_pkg::*;
#(
    parameter int unsigned WIDTH = OFM_W,
    parameter int unsigned DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         i_push,
    input  logic [WIDTH-1:0]             i_data,
    input  logic                         i_pop,
    output logic [WIDTH-1:0]             o_data,
    output logic                         o_valid,
    output logic                         o_full,
    output logic [$clog2(DEPTH+1)-1:0]   o_count
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_pop;
    logic             w_push;

    assign w_pop   = i_pop && (r_count != '0);
    assign w_push  = i_push && ((r_count != CW'(DEPTH)) || w_pop);
    assign o_data  = r_mem[r_rd_ptr];
    assign o_valid = (r_count != '0);
    assign o_full  = (r_count == CW'(DEPTH));
    assign o_count = r_count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) r_mem[i] <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= r_wr_ptr + AW'(1);
            end
            if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/psum_accum_requant.sv
// Accumulates MAC-array partial sums per pixel across channel groups, then biases, requantizes
// and queues int8/uint8 results. Define OFM_ROUND_EN for round-half-up instead of floor shift.
module psum_accum_requant
    import psum_accum_requant_pkg::*;
#(
    parameter int unsigned TILE_PIX   = 16,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_start,
    input  logic [4:0]              i_cfg_tile_pix,
    input  logic [5:0]              i_cfg_grps,
    input  logic [5:0]              i_cfg_id_grp,
    input  logic                    i_cfg_id_en,
    input  logic [4:0]              i_cfg_id_shift,
    input  logic [31:0]             i_cfg_bias,
    input  logic [15:0]             i_cfg_mult,
    input  logic [4:0]              i_cfg_shift,
    input  logic                    i_cfg_relu,
    input  logic                    i_psum_vld,
    input  logic [P3_W-1:0]         i_psum_3x3,
    input  logic [P1_W-1:0]         i_psum_1x1,
    input  logic [7:0]              i_identity,
    output logic                    o_stall,
    output logic [OFM_W-1:0]        o_ofm_data,
    output logic                    o_ofm_valid,
    input  logic                    i_ofm_ready,
    output logic                    o_busy,
    output logic                    o_done,
    output logic                    o_ovf_err
);
    localparam int unsigned PIX_W = $clog2(TILE_PIX);
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

    state_t                    r_state;
    logic [4:0]                r_tile_pix;
    logic [4:0]                r_pix_cnt;
    logic [5:0]                r_grps;
    logic [5:0]                r_grp_cnt;
    logic [5:0]                r_id_grp;
    logic                      r_id_en;
    logic [4:0]                r_id_shift;
    logic [ACC_W-1:0]          r_bias;
    logic signed [15:0]        r_mult;
    logic [4:0]                r_shift;
    logic                      r_relu;
    logic                      r_busy;
    logic                      r_done;
    logic                      r_ovf;
    logic                      r_stall;

    logic [ACC_W-1:0]          r_acc [TILE_PIX];

    logic                      r_s1_v;
    logic signed [ACC_W-1:0]   r_s1_b;
    logic                      r_s2_v;
    logic signed [PROD_W-1:0]  r_s2_p;
    logic                      r_s3_v;
    logic [OFM_W-1:0]          r_s3_q;

    logic                      w_take;
    logic                      w_last_pix;
    logic                      w_last_grp;
    logic [ACC_W-1:0]          w_base;
    logic [ACC_W-1:0]          w_p1_ext;
    logic [ACC_W-1:0]          w_id;
    logic [ACC_W-1:0]          w_sum;
    logic signed [PROD_W-1:0]  w_prod;
    logic signed [PROD_W-1:0]  w_rnd;
    logic signed [PROD_W-1:0]  w_q;
    logic                      w_pop;
    logic                      w_full;
    logic                      w_ovf;
    logic                      w_pipe_empty;
    logic [CNT_W-1:0]          w_fifo_count;
    logic [CNT_W:0]            w_total;

    // Accumulation datapath: group 0 starts from zero so the buffer never needs clearing.
    assign w_take     = (r_state == ST_ACCUM) && i_psum_vld;
    assign w_last_pix = (r_pix_cnt == r_tile_pix - 5'd1);
    assign w_last_grp = (r_grp_cnt == r_grps - 6'd1);
    assign w_base     = (r_grp_cnt == 6'd0) ? '0 : r_acc[r_pix_cnt[PIX_W-1:0]];
    assign w_p1_ext   = {{(ACC_W-P1_W){i_psum_1x1[P1_W-1]}}, i_psum_1x1};
    assign w_id       = (r_id_en && (r_grp_cnt == r_id_grp))
                        ? (ACC_W'(i_identity) << r_id_shift) : '0;
    assign w_sum      = w_base + i_psum_3x3 + w_p1_ext + w_id;

    assign w_prod = PROD_W'(r_s1_b) * PROD_W'(r_mult);
`ifdef OFM_ROUND_EN
    assign w_rnd  = (r_shift != 5'd0) ? (PROD_W'(1) << (r_shift - 5'd1)) : '0;
`else
    assign w_rnd  = '0;
`endif
    assign w_q    = (r_s2_p + w_rnd) >>> r_shift;

    assign w_pop        = o_ofm_valid && i_ofm_ready;
    assign w_ovf        = r_s3_v && w_full && !w_pop;
    assign w_pipe_empty = !(r_s1_v || r_s2_v || r_s3_v);
    assign w_total      = (CNT_W+1)'(w_fifo_count) + (CNT_W+1)'(r_s1_v)
                        + (CNT_W+1)'(r_s2_v) + (CNT_W+1)'(r_s3_v);

    always_ff @(posedge clk) begin
        if (w_take && !w_last_grp) r_acc[r_pix_cnt[PIX_W-1:0]] <= w_sum;
    end

    // Control FSM plus the three requant stages.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_tile_pix <= '0;
            r_pix_cnt  <= '0;
            r_grps     <= '0;
            r_grp_cnt  <= '0;
            r_id_grp   <= '0;
            r_id_en    <= 1'b0;
            r_id_shift <= '0;
            r_bias     <= '0;
            r_mult     <= '0;
            r_shift    <= '0;
            r_relu     <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_ovf      <= 1'b0;
            r_stall    <= 1'b0;
            r_s1_v     <= 1'b0;
            r_s1_b     <= '0;
            r_s2_v     <= 1'b0;
            r_s2_p     <= '0;
            r_s3_v     <= 1'b0;
            r_s3_q     <= '0;
        end else begin
            r_done  <= 1'b0;
            r_s1_v  <= w_take && w_last_grp;
            r_s1_b  <= w_sum + r_bias;
            r_s2_v  <= r_s1_v;
            r_s2_p  <= w_prod;
            r_s3_v  <= r_s2_v;
            r_s3_q  <= sat_ofm(w_q, r_relu);
            r_stall <= (w_total >= (CNT_W+1)'(FIFO_DEPTH - 4));
            if (w_ovf) r_ovf <= 1'b1;

            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_tile_pix <= (i_cfg_tile_pix == 5'd0) ? 5'(TILE_PIX) : i_cfg_tile_pix;
                        r_grps     <= (i_cfg_grps == 6'd0) ? 6'd1 : i_cfg_grps;
                        r_id_grp   <= i_cfg_id_grp;
                        r_id_en    <= i_cfg_id_en;
                        r_id_shift <= i_cfg_id_shift;
                        r_bias     <= i_cfg_bias;
                        r_mult     <= i_cfg_mult;
                        r_shift    <= i_cfg_shift;
                        r_relu     <= i_cfg_relu;
                        r_pix_cnt  <= '0;
                        r_grp_cnt  <= '0;
                        r_ovf      <= 1'b0;
                        r_busy     <= 1'b1;
                        r_state    <= ST_ACCUM;
                    end
                end
                ST_ACCUM: begin
                    if (w_take) begin
                        if (w_last_pix) begin
                            r_pix_cnt <= '0;
                            if (w_last_grp) r_state <= ST_DRAIN;
                            else            r_grp_cnt <= r_grp_cnt + 6'd1;
                        end else begin
                            r_pix_cnt <= r_pix_cnt + 5'd1;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (w_pipe_empty && (w_fifo_count == CNT_W'(1)) && w_pop) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else if (w_pipe_empty && (w_fifo_count == '0)) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    ofm_sync_fifo #(
        .WIDTH (OFM_W),
        .DEPTH (FIFO_DEPTH)
    ) u_ofm_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (r_s3_v),
        .i_data  (r_s3_q),
        .i_pop   (w_pop),
        .o_data  (o_ofm_data),
        .o_valid (o_ofm_valid),
        .o_full  (w_full),
        .o_count (w_fifo_count)
    );

    assign o_stall   = r_stall;
    assign o_busy    = r_busy;
    assign o_done    = r_done;
    assign o_ovf_err = r_ovf;

endmodule

// File: tb/tb_psum_accum_requant.sv
// Directed plus randomized bench for psum_accum_requant against a per-pixel arithmetic model.
module tb_psum_accum_requant;
    localparam int TP = 16;
    localparam int FD = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_start;
    logic [4:0]  i_cfg_tile_pix;
    logic [5:0]  i_cfg_grps;
    logic [5:0]  i_cfg_id_grp;
    logic        i_cfg_id_en;
    logic [4:0]  i_cfg_id_shift;
    logic [31:0] i_cfg_bias;
    logic [15:0] i_cfg_mult;
    logic [4:0]  i_cfg_shift;
    logic        i_cfg_relu;
    logic        i_psum_vld;
    logic [31:0] i_psum_3x3;
    logic [23:0] i_psum_1x1;
    logic [7:0]  i_identity;
    logic        o_stall;
    logic [7:0]  o_ofm_data;
    logic        o_ofm_valid;
    logic        i_ofm_ready;
    logic        o_busy;
    logic        o_done;
    logic        o_ovf_err;

    always #5 clk = ~clk;

    psum_accum_requant #(.TILE_PIX(TP), .FIFO_DEPTH(FD)) dut (
        .clk(clk), .rst_n(rst_n), .i_start(i_start),
        .i_cfg_tile_pix(i_cfg_tile_pix), .i_cfg_grps(i_cfg_grps), .i_cfg_id_grp(i_cfg_id_grp),
        .i_cfg_id_en(i_cfg_id_en), .i_cfg_id_shift(i_cfg_id_shift), .i_cfg_bias(i_cfg_bias),
        .i_cfg_mult(i_cfg_mult), .i_cfg_shift(i_cfg_shift), .i_cfg_relu(i_cfg_relu),
        .i_psum_vld(i_psum_vld), .i_psum_3x3(i_psum_3x3), .i_psum_1x1(i_psum_1x1),
        .i_identity(i_identity), .o_stall(o_stall), .o_ofm_data(o_ofm_data),
        .o_ofm_valid(o_ofm_valid), .i_ofm_ready(i_ofm_ready), .o_busy(o_busy),
        .o_done(o_done), .o_ovf_err(o_ovf_err)
    );

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    byte unsigned got_q[$];
    byte unsigned exp_q[$];
    int p3 [8][16];
    int p1 [8][16];
    int idv[8][16];
    int c_pix, c_grps, c_id_grp, c_id_en, c_id_shift, c_bias, c_mult, c_shift, c_relu;
    bit rnd_ready = 1'b0;
    bit saw_stall = 1'b0;

    // Record every handshaken byte and every done pulse.
    always @(negedge clk) begin
        if (rst_n && o_ofm_valid && i_ofm_ready) got_q.push_back(o_ofm_data);
        if (rst_n && o_done) done_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rnd_ready) i_ofm_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic cfg_default();
        c_pix = 1; c_grps = 1; c_id_en = 0; c_id_grp = 0; c_id_shift = 0;
        c_bias = 0; c_mult = 1; c_shift = 0; c_relu = 0;
    endtask

    task automatic clr_data();
        for (int g = 0; g < 8; g++)
            for (int p = 0; p < 16; p++) begin
                p3[g][p] = 0; p1[g][p] = 0; idv[g][p] = 0;
            end
    endtask

    // Reference: plain per-pixel sum over groups, then bias, multiply, shift, saturate.
    task automatic model();
        int np, ng, s, b, lo, hi;
        longint pr, q;
        exp_q.delete();
        np = (c_pix == 0) ? TP : c_pix;
        ng = (c_grps == 0) ? 1 : c_grps;
        for (int p = 0; p < np; p++) begin
            s = 0;
            for (int g = 0; g < ng; g++) begin
                s += p3[g][p] + p1[g][p];
                if (c_id_en != 0 && g == c_id_grp) s += idv[g][p] << c_id_shift;
            end
            b  = s + c_bias;
            pr = longint'(b) * longint'(c_mult);
`ifdef OFM_ROUND_EN
            if (c_shift > 0) pr += longint'(1) << (c_shift - 1);
`endif
            q  = pr >>> c_shift;
            lo = (c_relu != 0) ? 0 : -128;
            hi = (c_relu != 0) ? 255 : 127;
            if (q < longint'(lo)) q = longint'(lo);
            if (q > longint'(hi)) q = longint'(hi);
            exp_q.push_back(8'(q));
        end
    endtask

    task automatic do_start();
        i_cfg_tile_pix = 5'(c_pix);   i_cfg_grps   = 6'(c_grps);
        i_cfg_id_grp   = 6'(c_id_grp); i_cfg_id_en = 1'(c_id_en);
        i_cfg_id_shift = 5'(c_id_shift); i_cfg_bias = 32'(c_bias);
        i_cfg_mult     = 16'(c_mult); i_cfg_shift  = 5'(c_shift);
        i_cfg_relu     = 1'(c_relu);
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
    endtask

    task automatic drive_psum(input int g, input int p);
        i_psum_vld = 1'b1;
        i_psum_3x3 = 32'(p3[g][p]);
        i_psum_1x1 = 24'(p1[g][p]);
        i_identity = 8'(idv[g][p]);
        tick();
        i_psum_vld = 1'b0;
    endtask

    task automatic feed(input bit honour, input bit release_ready);
        int np, ng, w;
        np = (c_pix == 0) ? TP : c_pix;
        ng = (c_grps == 0) ? 1 : c_grps;
        for (int g = 0; g < ng; g++)
            for (int p = 0; p < np; p++) begin
                if (honour) begin
                    w = 0;
                    while (o_stall && w < 3000) begin
                        saw_stall = 1'b1;
                        tick();
                        w++;
                        if (w == 20 && release_ready) i_ofm_ready = 1'b1;
                    end
                    if (w >= 3000) chk("stall_timeout", 64'(1), 64'(0));
                end
                drive_psum(g, p);
            end
    endtask

    task automatic wait_done(input string tag, input int d0, input int budget);
        int n = 0;
        while (done_cnt == d0 && n < budget) begin
            tick();
            n++;
        end
        chk({tag, "_done"}, 64'(done_cnt - d0), 64'(1));
    endtask

    task automatic compare(input string tag, input int base, input int n);
        chk({tag, "_count"}, 64'(got_q.size() - base), 64'(n));
        for (int i = 0; i < n; i++)
            if (base + i < got_q.size())
                chk($sformatf("%s_b%0d", tag, i), 64'(got_q[base + i]), 64'(exp_q[i]));
    endtask

    task automatic run_tile(input string tag, input bit restart);
        int base, d0;
        base = got_q.size();
        d0   = done_cnt;
        model();
        do_start();
        if (restart) begin
            i_cfg_tile_pix = 5'd1; i_cfg_mult = 16'd7; i_cfg_grps = 6'd1;
            i_start = 1'b1;
            tick();
            i_start = 1'b0;
        end
        feed(1'b1, 1'b0);
        wait_done(tag, d0, 3000);
        compare(tag, base, exp_q.size());
        chk({tag, "_busy"}, 64'(o_busy), 64'(0));
    endtask

    task automatic simple(input string tag, input int s3, input int relu, input int mult,
                          input int shift);
        cfg_default(); clr_data();
        p3[0][0] = s3; c_relu = relu; c_mult = mult; c_shift = shift;
        run_tile(tag, 1'b0);
    endtask

    task automatic rand_tile(input string tag, input bit wide);
        int ng, np;
        cfg_default(); clr_data();
        c_pix = $urandom_range(0, 16); c_grps = $urandom_range(0, 4);
        c_id_en = $urandom_range(0, 1); c_id_grp = $urandom_range(0, 3);
        c_id_shift = $urandom_range(0, 4); c_relu = $urandom_range(0, 1);
        c_bias = int'($urandom_range(0, 10000)) - 5000;
        c_mult = int'($urandom_range(0, 600)) - 300;
        c_shift = $urandom_range(0, 10);
        if (wide) begin
            c_mult = int'(signed'(16'($urandom)));
            c_shift = $urandom_range(20, 31);
            c_id_shift = $urandom_range(0, 31);
        end
        np = (c_pix == 0) ? TP : c_pix;
        ng = (c_grps == 0) ? 1 : c_grps;
        for (int g = 0; g < ng; g++)
            for (int p = 0; p < np; p++) begin
                p3[g][p]  = wide ? int'($urandom) : int'($urandom_range(0, 4000)) - 2000;
                p1[g][p]  = wide ? int'(signed'(24'($urandom)))
                                 : int'($urandom_range(0, 4000)) - 2000;
                idv[g][p] = $urandom_range(0, 255);
            end
        run_tile(tag, 1'b0);
    endtask

    initial begin
        int base, d0, n;
        rst_n = 1'b0; i_start = 1'b0; i_psum_vld = 1'b0; i_ofm_ready = 1'b1;
        i_psum_3x3 = '0; i_psum_1x1 = '0; i_identity = '0;
        cfg_default(); clr_data();
        i_cfg_tile_pix = '0; i_cfg_grps = '0; i_cfg_id_grp = '0; i_cfg_id_en = 1'b0;
        i_cfg_id_shift = '0; i_cfg_bias = '0; i_cfg_mult = '0; i_cfg_shift = '0;
        i_cfg_relu = 1'b0;
        repeat (3) tick();
        chk("rst_data",  64'(o_ofm_data),  64'(0));
        chk("rst_valid", 64'(o_ofm_valid), 64'(0));
        chk("rst_busy",  64'(o_busy),      64'(0));
        chk("rst_done",  64'(o_done),      64'(0));
        chk("rst_ovf",   64'(o_ovf_err),   64'(0));
        chk("rst_stall", 64'(o_stall),     64'(0));
        rst_n = 1'b1;
        tick();

        // Single pixel, single group; also measures result latency.
        cfg_default(); clr_data();
        p3[0][0] = 100; p1[0][0] = -4;
        base = got_q.size(); d0 = done_cnt;
        model();
        chk("t1_model", 64'(exp_q[0]), 64'(96));
        do_start();
        chk("t1_busy", 64'(o_busy), 64'(1));
        drive_psum(0, 0);
        n = 1;
        while (!o_ofm_valid && n < 20) begin tick(); n++; end
        chk("t1_latency", 64'(n), 64'(4));
        wait_done("t1", d0, 100);
        compare("t1", base, 1);

        // Three groups over four pixels, with an ignored start mid-tile.
        cfg_default(); clr_data();
        c_grps = 3; c_pix = 4;
        for (int g = 0; g < 3; g++) for (int p = 0; p < 4; p++) p3[g][p] = 10 + p;
        run_tile("t2", 1'b1);

        // Identity branch on group 1, then on a group that never occurs.
        cfg_default(); clr_data();
        c_grps = 2; c_id_en = 1; c_id_grp = 1; c_id_shift = 2;
        for (int g = 0; g < 2; g++) idv[g][0] = 5;
        run_tile("t3a", 1'b0);
        chk("t3a_val", 64'(exp_q[0]), 64'(20));
        c_id_grp = 3;
        run_tile("t3b", 1'b0);

        // Clamp and rounding edges.
        simple("t4_relu_neg", -1000, 1, 1, 0);
        simple("t4_s8_pos",    1000, 0, 1, 0);
        simple("t4_round",        3, 0, 1, 1);
        simple("t4_neg_s8",   -1000, 0, 1, 0);

        // Backpressure honoured: FIFO never overflows, all 16 bytes arrive in order.
        cfg_default(); clr_data();
        c_pix = 16; c_mult = 3;
        for (int p = 0; p < 16; p++) p3[0][p] = p * 5 - 20;
        base = got_q.size(); d0 = done_cnt;
        model();
        i_ofm_ready = 1'b0; saw_stall = 1'b0;
        do_start();
        feed(1'b1, 1'b1);
        chk("t5a_saw_stall", 64'(saw_stall), 64'(1));
        wait_done("t5a", d0, 500);
        compare("t5a", base, 16);
        chk("t5a_ovf", 64'(o_ovf_err), 64'(0));

        // Backpressure ignored: only FIFO_DEPTH bytes survive, overflow is flagged.
        base = got_q.size(); d0 = done_cnt;
        i_ofm_ready = 1'b0;
        do_start();
        feed(1'b0, 1'b0);
        repeat (8) tick();
        chk("t5b_ovf", 64'(o_ovf_err), 64'(1));
        i_ofm_ready = 1'b1;
        wait_done("t5b", d0, 200);
        compare("t5b", base, FD);
        chk("t5b_ovf_held", 64'(o_ovf_err), 64'(1));

        // Reset in the middle of accumulation; new tile must be clean.
        cfg_default(); clr_data();
        c_grps = 2; c_pix = 4;
        for (int p = 0; p < 4; p++) begin p3[0][p] = 77; p3[1][p] = 9; end
        do_start();
        chk("t6_ovf_clr", 64'(o_ovf_err), 64'(0));
        for (int p = 0; p < 3; p++) drive_psum(0, p);
        d0 = done_cnt;
        rst_n = 1'b0;
        tick(); tick();
        chk("t6_rst_busy",  64'(o_busy),      64'(0));
        chk("t6_rst_valid", 64'(o_ofm_valid), 64'(0));
        chk("t6_rst_data",  64'(o_ofm_data),  64'(0));
        chk("t6_rst_stall", 64'(o_stall),     64'(0));
        rst_n = 1'b1;
        tick();
        chk("t6_no_done", 64'(done_cnt - d0), 64'(0));
        for (int p = 0; p < 4; p++) begin p3[0][p] = 40 + p; p1[1][p] = -p; end
        run_tile("t6", 1'b0);

        // Randomized tiles with random downstream readiness.
        rnd_ready = 1'b1;
        for (int k = 0; k < 6; k++) rand_tile($sformatf("rnd%0d", k), 1'b0);
        for (int k = 0; k < 2; k++) rand_tile($sformatf("wide%0d", k), 1'b1);
        rnd_ready = 1'b0;
        i_ofm_ready = 1'b1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
